// File: rtl/carfield_apb_periph_demux.sv
// APB demux for the Carfield peripheral window: registers each host access onto one of five
// downstream APB targets. Optional downstream timeout is built when CARFIELD_APB_TIMEOUT_EN is defined.
module carfield_apb_periph_demux #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned CanEnable     = 1,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AddrWidth-1:0]     s_paddr_i,
    input  logic                     s_psel_i,
    input  logic                     s_penable_i,
    input  logic                     s_pwrite_i,
    input  logic [DataWidth-1:0]     s_pwdata_i,
    input  logic [DataWidth/8-1:0]   s_pstrb_i,
    output logic [DataWidth-1:0]     s_prdata_o,
    output logic                     s_pready_o,
    output logic                     s_pslverr_o,
    output logic [4:0]               m_psel_o,
    output logic                     m_penable_o,
    output logic [AddrWidth-1:0]     m_paddr_o,
    output logic                     m_pwrite_o,
    output logic [DataWidth-1:0]     m_pwdata_o,
    output logic [DataWidth/8-1:0]   m_pstrb_o,
    input  logic [5*DataWidth-1:0]   m_prdata_i,
    input  logic [4:0]               m_pready_i,
    input  logic [4:0]               m_pslverr_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned NumTgt    = 5;

    localparam logic [AddrWidth-1:0] CanBase   = AddrWidth'(32'h2000_1000);
    localparam logic [AddrWidth-1:0] TimerBase = AddrWidth'(32'h2000_4000);
    localparam logic [AddrWidth-1:0] AdvBase   = AddrWidth'(32'h2000_5000);
    localparam logic [AddrWidth-1:0] WdogBase  = AddrWidth'(32'h2000_7000);
    localparam logic [AddrWidth-1:0] HypBase   = AddrWidth'(32'h2000_9000);

    if ((TimeoutCycles < 2) || (TimeoutCycles > 65535)) begin : gen_timeout_range_check
        $error("TimeoutCycles must be within 2..65535");
    end

    typedef enum logic [1:0] {StIdle, StFsetup, StFaccess, StResp} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   write_q, write_d;
    logic [DataWidth-1:0]   wdata_q, wdata_d;
    logic [StrbWidth-1:0]   strb_q, strb_d;
    logic [NumTgt-1:0]      sel_q, sel_d;
    logic [DataWidth-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   drop_q, drop_d;

    logic [NumTgt-1:0]      hit_sel;
    logic [AddrWidth-13:0]  page;
    logic                   tgt_ready;
    logic                   tgt_err;
    logic [DataWidth-1:0]   tgt_rdata;
    logic                   dropped;
    logic                   timeout_hit;

    assign page = s_paddr_i[AddrWidth-1:12];

    always_comb begin
        hit_sel = '0;
        if ((CanEnable != 0) && (page == CanBase[AddrWidth-1:12])) hit_sel[0] = 1'b1;
        if (page == TimerBase[AddrWidth-1:12]) hit_sel[1] = 1'b1;
        if (page == AdvBase[AddrWidth-1:12])   hit_sel[2] = 1'b1;
        if (page == WdogBase[AddrWidth-1:12])  hit_sel[3] = 1'b1;
        if (page == HypBase[AddrWidth-1:12])   hit_sel[4] = 1'b1;
    end

    // Only the selected target's response lines are observed.
    always_comb begin
        tgt_rdata = '0;
        for (int unsigned i = 0; i < NumTgt; i++) begin
            if (sel_q[i]) tgt_rdata = tgt_rdata | m_prdata_i[i*DataWidth +: DataWidth];
        end
    end

    assign tgt_ready = |(m_pready_i & sel_q);
    assign tgt_err   = |(m_pslverr_i & sel_q);
    assign dropped   = drop_q | ~s_psel_i;

`ifdef CARFIELD_APB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StFsetup) begin
            cnt_d = '0;
        end else if ((state_q == StFaccess) && !tgt_ready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    assign timeout_hit = (state_q == StFaccess) && !tgt_ready &&
                         (cnt_q == 16'(TimeoutCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        drop_d  = drop_q;
        unique case (state_q)
            StIdle: begin
                if (s_psel_i && !s_penable_i) begin
                    addr_d  = s_paddr_i;
                    write_d = s_pwrite_i;
                    wdata_d = s_pwdata_i;
                    strb_d  = s_pstrb_i;
                    drop_d  = 1'b0;
                    if (|hit_sel) begin
                        sel_d   = hit_sel;
                        state_d = StFsetup;
                    end else begin
                        sel_d   = '0;
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StFsetup: begin
                drop_d  = dropped;
                state_d = StFaccess;
            end
            StFaccess: begin
                drop_d = dropped;
                if (tgt_ready) begin
                    rdata_d = write_q ? '0 : tgt_rdata;
                    err_d   = tgt_err;
                    state_d = dropped ? StIdle : StResp;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = dropped ? StIdle : StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    logic fwd_active;
    logic resp_active;

    assign fwd_active  = (state_q == StFsetup) || (state_q == StFaccess);
    assign resp_active = (state_q == StResp);

    always_comb begin
        s_pready_o  = resp_active;
        s_prdata_o  = resp_active ? rdata_q : '0;
        s_pslverr_o = resp_active ? err_q : 1'b0;
        m_psel_o    = fwd_active ? sel_q : '0;
        m_penable_o = (state_q == StFaccess);
        m_paddr_o   = fwd_active ? addr_q : '0;
        m_pwrite_o  = fwd_active ? write_q : 1'b0;
        m_pwdata_o  = fwd_active ? wdata_q : '0;
        m_pstrb_o   = fwd_active ? strb_q : '0;
    end

endmodule

// File: tb/tb_carfield_apb_periph_demux.sv
// Directed bench for carfield_apb_periph_demux; a second instance with CanEnable=0 checks the
// CAN-as-hole case.
module tb_carfield_apb_periph_demux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  s_paddr;
    logic         s_psel;
    logic         s_penable;
    logic         s_pwrite;
    logic [31:0]  s_pwdata;
    logic [3:0]   s_pstrb;
    logic [31:0]  s_prdata;
    logic         s_pready;
    logic         s_pslverr;
    logic [4:0]   m_psel;
    logic         m_penable;
    logic [31:0]  m_paddr;
    logic         m_pwrite;
    logic [31:0]  m_pwdata;
    logic [3:0]   m_pstrb;
    logic [159:0] m_prdata;
    logic [4:0]   m_pready;
    logic [4:0]   m_pslverr;

    logic [31:0]  n_prdata;
    logic         n_pready;
    logic         n_pslverr;
    logic [4:0]   n_psel;
    logic         n_penable;
    logic [31:0]  n_paddr;
    logic         n_pwrite;
    logic [31:0]  n_pwdata;
    logic [3:0]   n_pstrb;

    int checks = 0;
    int errors = 0;

    carfield_apb_periph_demux dut (
        .clk_i(clk), .rst_i(rst),
        .s_paddr_i(s_paddr), .s_psel_i(s_psel), .s_penable_i(s_penable),
        .s_pwrite_i(s_pwrite), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_prdata_o(s_prdata), .s_pready_o(s_pready), .s_pslverr_o(s_pslverr),
        .m_psel_o(m_psel), .m_penable_o(m_penable), .m_paddr_o(m_paddr),
        .m_pwrite_o(m_pwrite), .m_pwdata_o(m_pwdata), .m_pstrb_o(m_pstrb),
        .m_prdata_i(m_prdata), .m_pready_i(m_pready), .m_pslverr_i(m_pslverr)
    );

    carfield_apb_periph_demux #(.CanEnable(0)) dut_nocan (
        .clk_i(clk), .rst_i(rst),
        .s_paddr_i(s_paddr), .s_psel_i(s_psel), .s_penable_i(s_penable),
        .s_pwrite_i(s_pwrite), .s_pwdata_i(s_pwdata), .s_pstrb_i(s_pstrb),
        .s_prdata_o(n_prdata), .s_pready_o(n_pready), .s_pslverr_o(n_pslverr),
        .m_psel_o(n_psel), .m_penable_o(n_penable), .m_paddr_o(n_paddr),
        .m_pwrite_o(n_pwrite), .m_pwdata_o(n_pwdata), .m_pstrb_o(n_pstrb),
        .m_prdata_i({160{1'b0}}), .m_pready_i(5'b11111), .m_pslverr_i(5'b00000)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] strb);
        s_paddr   = addr;
        s_pwrite  = wr;
        s_pwdata  = wd;
        s_pstrb   = strb;
        s_psel    = 1'b1;
        s_penable = 1'b0;
    endtask

    task automatic release_bus();
        s_psel    = 1'b0;
        s_penable = 1'b0;
        s_paddr   = '0;
        s_pwrite  = 1'b0;
        s_pwdata  = '0;
        s_pstrb   = '0;
    endtask

    task automatic set_rdata(input int idx, input logic [31:0] v);
        m_prdata[idx*32 +: 32] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        release_bus();
        m_pready = 5'b11111;
        m_pslverr = '0;
        m_prdata = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({s_pready, s_pslverr, s_prdata} !== 34'd0) begin
            errors++;
            $display("FAIL reset_upstream got %h want 0", {s_pready, s_pslverr, s_prdata});
        end
        checks++;
        if ({m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pstrb} !== 75'd0) begin
            errors++;
            $display("FAIL reset_downstream got %h want 0",
                     {m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pstrb});
        end
    endtask

    task automatic test_timer_read();
        m_pready = 5'b11111;
        m_pslverr = 5'b11101;
        for (int i = 0; i < 5; i++) set_rdata(i, 32'hBAD0_0000 + i);
        set_rdata(1, 32'hDEAD_BEEF);
        setup(32'h2000_4010, 1'b0, 32'h0, 4'h0);
        tick(); // T+1
        checks++;
        if (m_psel !== 5'b00010 || m_penable !== 1'b0) begin
            errors++;
            $display("FAIL rd_fsetup got psel %b en %b want 00010 0", m_psel, m_penable);
        end
        checks++;
        if (m_paddr !== 32'h2000_4010 || s_pready !== 1'b0) begin
            errors++;
            $display("FAIL rd_paddr got %h rdy %b want 20004010 0", m_paddr, s_pready);
        end
        s_penable = 1'b1;
        tick(); // T+2
        checks++;
        if (m_psel !== 5'b00010 || m_penable !== 1'b1 || s_pready !== 1'b0) begin
            errors++;
            $display("FAIL rd_faccess got psel %b en %b rdy %b want 00010 1 0",
                     m_psel, m_penable, s_pready);
        end
        tick(); // T+3
        checks++;
        if (s_pready !== 1'b1 || s_prdata !== 32'hDEAD_BEEF || s_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp got rdy %b data %h err %b want 1 deadbeef 0",
                     s_pready, s_prdata, s_pslverr);
        end
        checks++;
        if (m_psel !== 5'b00000 || m_paddr !== 32'h0) begin
            errors++;
            $display("FAIL rd_resp_idle_bus got psel %b addr %h want 0 0", m_psel, m_paddr);
        end
        release_bus();
        tick();
        checks++;
        if (s_pready !== 1'b0 || s_prdata !== 32'h0) begin
            errors++;
            $display("FAIL rd_after got rdy %b data %h want 0 0", s_pready, s_prdata);
        end
    endtask

    task automatic test_hyper_write();
        m_pready = 5'b01111;
        m_pslverr = 5'b00000;
        set_rdata(4, 32'hFFFF_FFFF);
        setup(32'h2000_9004, 1'b1, 32'h1234_5678, 4'b0011);
        tick(); // T+1
        checks++;
        if (m_psel !== 5'b10000 || m_pwrite !== 1'b1 || m_pwdata !== 32'h1234_5678 ||
            m_pstrb !== 4'b0011) begin
            errors++;
            $display("FAIL wr_fwd got psel %b wr %b data %h strb %b want 10000 1 12345678 0011",
                     m_psel, m_pwrite, m_pwdata, m_pstrb);
        end
        s_penable = 1'b1;
        tick(); // T+2
        tick(); // T+3
        tick(); // T+4
        checks++;
        if (s_pready !== 1'b0 || m_penable !== 1'b1 || m_pwdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wr_wait got rdy %b en %b data %h want 0 1 12345678",
                     s_pready, m_penable, m_pwdata);
        end
        tick(); // T+5
        m_pready = 5'b11111;
        checks++;
        if (s_pready !== 1'b0) begin
            errors++;
            $display("FAIL wr_wait_last got rdy %b want 0", s_pready);
        end
        tick(); // T+6
        checks++;
        if (s_pready !== 1'b1 || s_prdata !== 32'h0 || s_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp got rdy %b data %h err %b want 1 0 0",
                     s_pready, s_prdata, s_pslverr);
        end
        release_bus();
        tick();
    endtask

    task automatic test_hole();
        setup(32'h2000_2000, 1'b0, 32'h0, 4'h0);
        tick(); // T+1
        checks++;
        if (s_pready !== 1'b1 || s_pslverr !== 1'b1 || s_prdata !== 32'h0 || m_psel !== 5'b0) begin
            errors++;
            $display("FAIL hole_resp got rdy %b err %b data %h psel %b want 1 1 0 0",
                     s_pready, s_pslverr, s_prdata, m_psel);
        end
        s_penable = 1'b1;
        tick();
        release_bus();
        checks++;
        if (s_pready !== 1'b0 || m_psel !== 5'b0) begin
            errors++;
            $display("FAIL hole_after got rdy %b psel %b want 0 0", s_pready, m_psel);
        end
        tick();
    endtask

    task automatic test_can_disabled();
        m_pready = 5'b11111;
        m_pslverr = 5'b00000;
        set_rdata(0, 32'h0000_0CA4);
        setup(32'h2000_1000, 1'b0, 32'h0, 4'h0);
        tick(); // T+1
        checks++;
        if (n_pready !== 1'b1 || n_pslverr !== 1'b1 || n_prdata !== 32'h0 || n_psel !== 5'b0) begin
            errors++;
            $display("FAIL nocan_hole got rdy %b err %b data %h psel %b want 1 1 0 0",
                     n_pready, n_pslverr, n_prdata, n_psel);
        end
        checks++;
        if (m_psel !== 5'b00001) begin
            errors++;
            $display("FAIL can_psel got %b want 00001", m_psel);
        end
        s_penable = 1'b1;
        tick();
        tick(); // T+3
        checks++;
        if (s_pready !== 1'b1 || s_prdata !== 32'h0000_0CA4 || s_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL can_resp got rdy %b data %h err %b want 1 00000ca4 0",
                     s_pready, s_prdata, s_pslverr);
        end
        release_bus();
        tick();
    endtask

    task automatic test_wdog_err();
        m_pready = 5'b11111;
        m_pslverr = 5'b01010;
        set_rdata(3, 32'h0000_7777);
        setup(32'h2000_7000, 1'b0, 32'h0, 4'h0);
        tick();
        s_penable = 1'b1;
        tick();
        tick(); // T+3
        checks++;
        if (s_pready !== 1'b1 || s_pslverr !== 1'b1 || s_prdata !== 32'h0000_7777) begin
            errors++;
            $display("FAIL wdog_err got rdy %b err %b data %h want 1 1 00007777",
                     s_pready, s_pslverr, s_prdata);
        end
        release_bus();
        m_pslverr = 5'b00000;
        tick();
    endtask

    task automatic test_stray_enable();
        s_paddr = 32'h2000_4000;
        s_psel = 1'b1;
        s_penable = 1'b1;
        tick();
        tick();
        checks++;
        if (m_psel !== 5'b0 || s_pready !== 1'b0) begin
            errors++;
            $display("FAIL stray_enable got psel %b rdy %b want 0 0", m_psel, s_pready);
        end
        release_bus();
        tick();
    endtask

    task automatic test_back_to_back();
        m_pready = 5'b11111;
        m_pslverr = 5'b00000;
        set_rdata(2, 32'h1111_2222);
        set_rdata(1, 32'h3333_4444);
        setup(32'h2000_5008, 1'b0, 32'h0, 4'h0);
        tick();
        s_penable = 1'b1;
        tick();
        tick(); // T+3 response A
        checks++;
        if (s_pready !== 1'b1 || s_prdata !== 32'h1111_2222) begin
            errors++;
            $display("FAIL b2b_first got rdy %b data %h want 1 11112222", s_pready, s_prdata);
        end
        tick(); // T+4 idle, new setup
        setup(32'h2000_400C, 1'b0, 32'h0, 4'h0);
        tick(); // T+5
        checks++;
        if (m_psel !== 5'b00010 || m_paddr !== 32'h2000_400C) begin
            errors++;
            $display("FAIL b2b_fsetup got psel %b addr %h want 00010 2000400c", m_psel, m_paddr);
        end
        s_penable = 1'b1;
        tick();
        tick(); // T+7
        checks++;
        if (s_pready !== 1'b1 || s_prdata !== 32'h3333_4444) begin
            errors++;
            $display("FAIL b2b_second got rdy %b data %h want 1 33334444", s_pready, s_prdata);
        end
        release_bus();
        tick();
    endtask

    task automatic test_drop();
        m_pready = 5'b11111;
        setup(32'h2000_4000, 1'b0, 32'h0, 4'h0);
        tick(); // T+1
        release_bus();
        tick(); // T+2 downstream still completes
        checks++;
        if (m_psel !== 5'b00010 || m_penable !== 1'b1) begin
            errors++;
            $display("FAIL drop_faccess got psel %b en %b want 00010 1", m_psel, m_penable);
        end
        tick(); // T+3 response dropped
        checks++;
        if (s_pready !== 1'b0 || m_psel !== 5'b0) begin
            errors++;
            $display("FAIL drop_resp got rdy %b psel %b want 0 0", s_pready, m_psel);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m_pready = 5'b00000;
        setup(32'h2000_7000, 1'b0, 32'h0, 4'h0);
        tick();
        s_penable = 1'b1;
        tick(); // FACCESS, stalled
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (m_psel !== 5'b0 || m_penable !== 1'b0 || s_pready !== 1'b0 || m_paddr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid got psel %b en %b rdy %b addr %h want 0 0 0 0",
                     m_psel, m_penable, s_pready, m_paddr);
        end
        release_bus();
        m_pready = 5'b11111;
        set_rdata(2, 32'hA5A5_0001);
        tick();
        setup(32'h2000_5000, 1'b0, 32'h0, 4'h0);
        tick();
        s_penable = 1'b1;
        tick();
        tick();
        checks++;
        if (s_pready !== 1'b1 || s_prdata !== 32'hA5A5_0001 || s_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL rst_recover got rdy %b data %h err %b want 1 a5a50001 0",
                     s_pready, s_prdata, s_pslverr);
        end
        release_bus();
        tick();
    endtask

`ifdef CARFIELD_APB_TIMEOUT_EN
    task automatic test_timeout();
        m_pready = 5'b11110;
        set_rdata(0, 32'hCAFE_0000);
        setup(32'h2000_1000, 1'b0, 32'h0, 4'h0);
        tick();
        s_penable = 1'b1;
        tick(); // first FACCESS cycle
        repeat (63) tick(); // 64th FACCESS cycle
        checks++;
        if (m_psel !== 5'b00001 || s_pready !== 1'b0) begin
            errors++;
            $display("FAIL to_last_wait got psel %b rdy %b want 00001 0", m_psel, s_pready);
        end
        tick();
        checks++;
        if (s_pready !== 1'b1 || s_pslverr !== 1'b1 || s_prdata !== 32'h0 || m_psel !== 5'b0) begin
            errors++;
            $display("FAIL to_resp got rdy %b err %b data %h psel %b want 1 1 0 0",
                     s_pready, s_pslverr, s_prdata, m_psel);
        end
        release_bus();
        tick();
        tick();
        m_pready = 5'b11111;
        tick();
        m_pready = 5'b11110;
        checks++;
        if (s_pready !== 1'b0) begin
            errors++;
            $display("FAIL to_late_ready got rdy %b want 0", s_pready);
        end
        tick();
        checks++;
        if (s_pready !== 1'b0 || m_psel !== 5'b0) begin
            errors++;
            $display("FAIL to_quiet got rdy %b psel %b want 0 0", s_pready, m_psel);
        end
        m_pready = 5'b11111;
    endtask
`endif

    initial begin
        test_reset();
        test_timer_read();
        test_hyper_write();
        test_hole();
        test_can_disabled();
        test_wdog_err();
        test_stray_enable();
        test_back_to_back();
        test_drop();
        test_reset_mid();
`ifdef CARFIELD_APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
